// File: rtl/unsharp_mask_sched.sv
// Round-robin job scheduler driving the unsharp_mask_hls ap_ctrl_hs handshake, with a watchdog that resets a hung core.
// Optional perf counters (perf_cycles, perf_jobs) are built when UMASK_SCHED_PERF_EN is defined.
module unsharp_mask_sched #(
    parameter int unsigned  NREQ    = 2,
    parameter int unsigned  BANK_W  = 2,
    parameter logic [31:0]  TIMEOUT = 32'd200000,
    parameter int unsigned  RST_CYC = 4,
    localparam int unsigned GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*BANK_W-1:0] req_bank,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_done,
    output logic                   rsp_err,
    output logic                   core_start,
    input  logic                   core_ready,
    input  logic                   core_done,
    input  logic                   core_idle,
    output logic                   core_rst,
    output logic [BANK_W-1:0]      bank_sel,
    output logic                   busy,
    output logic [GW-1:0]          grant_id
`ifdef UMASK_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [15:0]            perf_jobs
`endif
);

    typedef enum logic [2:0] {IDLE, START, RUN, RESP, RECOVER} state_t;

    state_t            state;
    logic [GW-1:0]     ptr;
    logic [31:0]       wd_cnt;
    logic [31:0]       rst_cnt;

    logic              pick_hit;
    logic [GW-1:0]     pick_idx;
    logic [GW-1:0]     nxt_ptr;
    logic [BANK_W-1:0] pick_bank;
    int unsigned       pick_pos;
    logic              finish_ok;
    logic              wd_term;

    // First valid requester at or after the round-robin pointer
    always_comb begin
        pick_hit  = 1'b0;
        pick_idx  = '0;
        pick_bank = '0;
        pick_pos  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pick_pos = (32'(ptr) + i) % NREQ;
            if (!pick_hit && req_valid[pick_pos[GW-1:0]]) begin
                pick_hit  = 1'b1;
                pick_idx  = pick_pos[GW-1:0];
                pick_bank = req_bank[pick_pos*BANK_W +: BANK_W];
            end
        end
    end

    assign nxt_ptr   = (pick_idx == GW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    // core_done beats the watchdog when both land in the same cycle
    assign finish_ok = (state == RUN && core_done) ||
                       (state == START && core_start && core_ready && core_done);
    assign wd_term   = (wd_cnt >= TIMEOUT - 32'd1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            wd_cnt     <= '0;
            rst_cnt    <= '0;
            req_ready  <= '0;
            rsp_done   <= '0;
            rsp_err    <= 1'b0;
            core_start <= 1'b0;
            core_rst   <= 1'b0;
            bank_sel   <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
        end else begin
            req_ready <= '0;
            rsp_done  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_hit && core_idle) begin
                        req_ready <= NREQ'(1) << pick_idx;
                        grant_id  <= pick_idx;
                        bank_sel  <= pick_bank;
                        ptr       <= nxt_ptr;
                        wd_cnt    <= '0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    wd_cnt <= wd_cnt + 32'd1;
                    if (finish_ok) begin
                        core_start <= 1'b0;
                        rsp_done   <= NREQ'(1) << grant_id;
                        state      <= RESP;
                    end else if (core_start && core_ready) begin
                        core_start <= 1'b0;
                        state      <= RUN;
                    end else if (wd_term) begin
                        core_start <= 1'b0;
                        core_rst   <= 1'b1;
                        rst_cnt    <= '0;
                        state      <= RECOVER;
                    end else begin
                        core_start <= 1'b1;
                    end
                end
                RUN: begin
                    wd_cnt <= wd_cnt + 32'd1;
                    if (finish_ok) begin
                        rsp_done <= NREQ'(1) << grant_id;
                        state    <= RESP;
                    end else if (wd_term) begin
                        core_rst <= 1'b1;
                        rst_cnt  <= '0;
                        state    <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (rst_cnt == 32'(RST_CYC - 1)) begin
                        core_rst <= 1'b0;
                        rsp_done <= NREQ'(1) << grant_id;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        rst_cnt <= rst_cnt + 32'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UMASK_SCHED_PERF_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else if (finish_ok) begin
            perf_cycles <= wd_cnt;
            perf_jobs   <= perf_jobs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unsharp_mask_sched.sv
// Scoreboard bench for unsharp_mask_sched: directed jobs, expected accepts/responses queued and checked by a monitor.
module tb_unsharp_mask_sched;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b1;
    logic [1:0] req_valid = '0;
    logic [3:0] req_bank = '0;
    logic [1:0] req_ready;
    logic [1:0] rsp_done;
    logic       rsp_err;
    logic       core_start;
    logic       core_ready = 1'b0;
    logic       core_done = 1'b0;
    logic       core_idle = 1'b1;
    logic       core_rst;
    logic [1:0] bank_sel;
    logic       busy;
    logic [0:0] grant_id;
`ifdef UMASK_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_jobs;
`endif

    unsharp_mask_sched #(
        .NREQ(2),
        .BANK_W(2),
        .TIMEOUT(32'd100),
        .RST_CYC(4)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .req_valid(req_valid),
        .req_bank(req_bank),
        .req_ready(req_ready),
        .rsp_done(rsp_done),
        .rsp_err(rsp_err),
        .core_start(core_start),
        .core_ready(core_ready),
        .core_done(core_done),
        .core_idle(core_idle),
        .core_rst(core_rst),
        .bank_sel(bank_sel),
        .busy(busy),
        .grant_id(grant_id)
`ifdef UMASK_SCHED_PERF_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_jobs(perf_jobs)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic [1:0] oh; logic gid; logic [1:0] bank;} acc_t;
    typedef struct packed {logic [1:0] oh; logic err;} rsp_t;
    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    acc_t ea;
    rsp_t er;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: every accept / response pulse must match the head of its queue
    always @(negedge ap_clk) begin
        if (ap_rst_n && req_ready != '0) begin
            checks++;
            if (exp_acc.size() == 0) begin
                errors++;
                $display("FAIL unexpected_accept: req_ready=%b grant_id=%0d, none expected", req_ready, grant_id);
            end else begin
                ea = exp_acc.pop_front();
                if ({req_ready, grant_id, bank_sel} !== ea) begin
                    errors++;
                    $display("FAIL accept: got ready=%b id=%0d bank=%0d expected ready=%b id=%0d bank=%0d",
                             req_ready, grant_id, bank_sel, ea.oh, ea.gid, ea.bank);
                end
            end
        end
        if (ap_rst_n && rsp_done != '0) begin
            checks++;
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rsp_done=%b rsp_err=%b, none expected", rsp_done, rsp_err);
            end else begin
                er = exp_rsp.pop_front();
                if ({rsp_done, rsp_err, core_rst} !== {er, 1'b0}) begin
                    errors++;
                    $display("FAIL response: got done=%b err=%b core_rst=%b expected done=%b err=%b core_rst=0",
                             rsp_done, rsp_err, core_rst, er.oh, er.err);
                end
            end
        end
    end

    // One job with a well-behaved core: ready after rdy_dly cycles of core_start, done done_dly cycles later
    task automatic core_job(input logic [1:0] exp_oh, input logic exp_gid, input logic [1:0] exp_bank,
                            input bit drop, input int rdy_dly, input int done_dly);
        int n;
        exp_acc.push_back({exp_oh, exp_gid, exp_bank});
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == '0 && n < 50);
        check("accept_seen", req_ready, exp_oh);
        if (drop) req_valid = req_valid & ~exp_oh;
        tick();
        check("start_rise", core_start, 1);
        repeat (rdy_dly) tick();
        check("start_hold", core_start, 1);
        check("bank_sel_job", bank_sel, exp_bank);
        core_ready = 1'b1;
        if (done_dly == 0) begin
            core_done = 1'b1;
            exp_rsp.push_back({exp_oh, 1'b0});
        end
        tick();
        core_ready = 1'b0;
        check("start_fall", core_start, 0);
        if (done_dly > 0) begin
            repeat (done_dly - 1) tick();
            core_done = 1'b1;
            exp_rsp.push_back({exp_oh, 1'b0});
            tick();
        end
        core_done = 1'b0;
        check("rsp_latency", {rsp_done, rsp_err}, {exp_oh, 1'b0});
        tick();
        check("idle_after_rsp", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;
        #1 ap_rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {req_ready, rsp_done, rsp_err, core_start, core_rst, bank_sel, busy, grant_id}, 0);
        ap_rst_n = 1'b1;
        tick();

        // Single job, requester 0, bank 3; then requester 1 so the pointer is back at 0
        req_bank  = 4'b00_11;
        req_valid = 2'b01;
        core_job(2'b01, 1'b0, 2'd3, 1'b1, 2, 50);
        req_bank  = 4'b10_11;
        req_valid = 2'b10;
        core_job(2'b10, 1'b1, 2'd2, 1'b1, 0, 10);

        // Fairness with both requesters held
        req_bank  = 4'b01_10;
        req_valid = 2'b11;
        core_job(2'b01, 1'b0, 2'd2, 1'b0, 1, 5);
        core_job(2'b10, 1'b1, 2'd1, 1'b0, 1, 5);
        core_job(2'b01, 1'b0, 2'd2, 1'b1, 0, 3);
        core_job(2'b10, 1'b1, 2'd1, 1'b1, 0, 3);

        // Watchdog timeout: core never answers
        req_bank  = 4'b00_01;
        req_valid = 2'b01;
        exp_acc.push_back({2'b01, 1'b0, 2'd1});
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == '0 && n < 50);
        check("to_accept", req_ready, 2'b01);
        req_valid = 2'b00;
        repeat (99) tick();
        check("wd_before_term", core_rst, 0);
        check("start_while_hung", core_start, 1);
        exp_rsp.push_back({2'b01, 1'b1});
        tick();
        check("wd_fire", core_rst, 1);
        check("start_drop_on_abort", core_start, 0);
        n = 0;
        while (core_rst && n < 20) begin
            tick();
            n++;
        end
        check("rst_cycles", n, 4);
        check("abort_rsp", {rsp_done, rsp_err}, {2'b01, 1'b1});
        tick();
        check("idle_after_abort", busy, 0);

        // Race: done at the terminal watchdog count (count 99)
        req_bank  = 4'b10_00;
        req_valid = 2'b10;
        core_job(2'b10, 1'b1, 2'd2, 1'b1, 0, 98);
        check("race_no_rst", core_rst, 0);

        // Idle gate
        core_idle = 1'b0;
        req_bank  = 4'b00_10;
        req_valid = 2'b01;
        bad = 0;
        repeat (6) begin
            tick();
            if (req_ready != '0) bad++;
        end
        check("idle_gate", bad, 0);
        core_idle = 1'b1;

        // Reset while in RUN
        exp_acc.push_back({2'b01, 1'b0, 2'd2});
        n = 0;
        do begin
            tick();
            n++;
        end while (req_ready == '0 && n < 50);
        check("gate_release_accept", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        repeat (2) tick();
        check("busy_in_run", busy, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("async_reset", {req_ready, rsp_done, rsp_err, core_start, core_rst, bank_sel, busy, grant_id}, 0);
        repeat (2) tick();
        ap_rst_n = 1'b1;
        core_done = 1'b1;
        bad = 0;
        repeat (6) begin
            tick();
            core_done = 1'b0;
            if (rsp_done != '0 || busy) bad++;
        end
        check("no_rsp_after_rst", bad, 0);

        // Pointer was 1 before reset; reset returns it to 0
        req_bank  = 4'b11_01;
        req_valid = 2'b11;
        core_job(2'b01, 1'b0, 2'd1, 1'b1, 0, 3);
        core_job(2'b10, 1'b1, 2'd3, 1'b1, 0, 3);

`ifdef UMASK_SCHED_PERF_EN
        ap_rst_n = 1'b0;
        tick();
        check("perf_reset", {perf_cycles, perf_jobs}, 0);
        ap_rst_n = 1'b1;
        tick();
        req_bank = 4'b00_00;
        for (int j = 0; j < 3; j++) begin
            req_valid = 2'b01;
            core_job(2'b01, 1'b0, 2'd0, 1'b1, 0, 39);
            if (j == 0) check("perf_jobs_first", perf_jobs, 1);
            req_valid = 2'b10;
            exp_acc.push_back({2'b10, 1'b1, 2'd0});
            n = 0;
            do begin
                tick();
                n++;
            end while (req_ready == '0 && n < 50);
            req_valid = 2'b00;
            tick();
            exp_rsp.push_back({2'b10, 1'b1});
            n = 0;
            while (!(rsp_done != '0) && n < 200) begin
                tick();
                n++;
            end
            tick();
        end
        check("perf_jobs", perf_jobs, 3);
        check("perf_cycles", perf_cycles, 40);
`endif

        repeat (3) tick();
        check("scoreboard_drained", exp_acc.size() + exp_rsp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
